// File: rtl/mips_mem_pkg.sv
// Purpose : shared memory-bus encodings and fetch state type for the MIPS front end.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mips_mem_pkg;

   // access_size encodings on the memory request bus
   localparam logic [1:0] AS_WORD    = 2'b00;
   localparam logic [1:0] AS_BURST4  = 2'b01;
   localparam logic [1:0] AS_BURST8  = 2'b10;
   localparam logic [1:0] AS_BURST16 = 2'b11;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   localparam int LINE_WORDS = 16;
   localparam int LINE_BYTES = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_FILL,
      ST_SERVE,
      ST_DRAIN
   } fetch_state_t;

endpackage

// File: rtl/mips_fetch_if.sv
// Purpose : bundles the fetch stage's decode-side handshake and memory burst bus.
// Latency : n/a (wires only).
// Backpressure: instr_ready from decode; mem_busy from memory.
// Ports   : master = fetch stage, slave = environment (decode, redirect source, memory).
interface mips_fetch_if;
   import mips_mem_pkg::*;

   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] mem_addr;
   logic        mem_enable;
   logic        mem_rw;
   logic [1:0]  mem_access_size;
   logic [31:0] mem_dout;
   logic        mem_busy;

   modport master (
      input  redirect_valid, redirect_pc, instr_ready, mem_dout, mem_busy,
      output instr_valid, instr, instr_pc, mem_addr, mem_enable, mem_rw, mem_access_size
   );

   modport slave (
      output redirect_valid, redirect_pc, instr_ready, mem_dout, mem_busy,
      input  instr_valid, instr, instr_pc, mem_addr, mem_enable, mem_rw, mem_access_size
   );

endinterface

// File: rtl/mips_fetch_line_buf.sv
// Purpose : 16x32 instruction line buffer with per-word valid mask.
// Latency : write lands at the clock edge; read port is combinational off the registers.
// Backpressure: none; writer controls i_wr_en, clear has priority over a same-cycle write.
// Ports   : i_wr_* burst write port, i_wv_clr mask clear, i_rd_idx read index, o_rd_dat/o_rd_vld read data and its valid bit.
module fetch_line_buf
   import mips_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_wr_en,
   input  logic [3:0]  i_wr_idx,
   input  logic [31:0] i_wr_dat,
   input  logic        i_wv_clr,
   input  logic [3:0]  i_rd_idx,
   output logic [31:0] o_rd_dat,
   output logic        o_rd_vld
);

   logic [31:0]           r_mem [LINE_WORDS];
   logic [LINE_WORDS-1:0] r_wv;

   // Array is reset so the instruction output reads zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            r_mem[i] <= '0;
         end
         r_wv <= '0;
      end else begin
         if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_dat;
         end
         if (i_wv_clr) begin
            r_wv <= '0;
         end else if (i_wr_en) begin
            r_wv[i_wr_idx] <= 1'b1;
         end
      end
   end

   assign o_rd_dat = r_mem[i_rd_idx];
   assign o_rd_vld = r_wv[i_rd_idx];

endmodule

// File: rtl/mips_fetch.sv
// Purpose : instruction fetch; bursts 64-byte lines into a line buffer and streams words to decode.
// Latency : first instr_valid 3 cycles after reset release; 1 instr/cycle while streaming a line.
// Backpressure: instr_ready low holds instr/instr_pc; no request issued while mem_busy is high.
// Ports   : clk, rst_n (async active-low), bus (mips_fetch_if.master: redirect, decode handshake, memory burst bus).
module mips_fetch
   import mips_mem_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h8002_0000
)
(
   input  logic         clk,
   input  logic         rst_n,
   mips_fetch_if.master bus
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nxt;
   logic [25:0]  r_tag;
   logic [3:0]   r_fcnt;

   logic [31:0]  w_rd_dat;
   logic         w_rd_vld;
   logic [31:0]  w_redir_pc;
   logic [31:0]  w_pc_inc;
   logic         w_valid;
   logic         w_fire;
   logic         w_issue;
   logic         w_redir_far;
   logic         w_last;
   logic         w_wv_clr;

   assign w_redir_pc  = bus.redirect_pc & ~32'd3;
   assign w_pc_inc    = r_pc + 32'd4;
   assign w_valid     = ((r_state == ST_FILL) || (r_state == ST_SERVE)) &&
                        (r_pc[31:6] == r_tag) && w_rd_vld;
   assign w_fire      = w_valid && bus.instr_ready;
   assign w_redir_far = bus.redirect_valid && (w_redir_pc[31:6] != r_tag);
   assign w_last      = (r_fcnt == 4'd15);
   // A redirect arriving in the request cycle would make the issued line stale,
   // so the request is held off for that cycle and goes out with the new pc.
   assign w_issue     = (r_state == ST_REQ) && !bus.mem_busy && !bus.redirect_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_wv_clr    = 1'b0;

      if (bus.redirect_valid) begin
         w_pc_nxt = w_redir_pc;
      end else if (w_fire) begin
         w_pc_nxt = w_pc_inc;
      end

      case (r_state)
         ST_IDLE: w_state_nxt = ST_REQ;
         ST_REQ: begin
            if (w_issue) begin
               w_state_nxt = ST_FILL;
               w_wv_clr    = 1'b1;
            end
         end
         ST_FILL: begin
            // Burst keeps arriving regardless; a far redirect on the last word
            // has nothing left to drain.
            if (w_redir_far) begin
               w_state_nxt = w_last ? ST_REQ : ST_DRAIN;
               w_wv_clr    = 1'b1;
            end else if (w_last) begin
               w_state_nxt = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (w_redir_far) begin
               w_state_nxt = ST_REQ;
            end else if (!bus.redirect_valid && w_fire && (w_pc_inc[31:6] != r_tag)) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (w_last) begin
               w_state_nxt = ST_REQ;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
         r_tag   <= '0;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (w_issue) begin
            r_tag  <= r_pc[31:6];
            r_fcnt <= '0;
         end else if ((r_state == ST_FILL) || (r_state == ST_DRAIN)) begin
            r_fcnt <= r_fcnt + 4'd1;
         end
      end
   end

   fetch_line_buf u_line_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_wr_en  (r_state == ST_FILL),
      .i_wr_idx (r_fcnt),
      .i_wr_dat (bus.mem_dout),
      .i_wv_clr (w_wv_clr),
      .i_rd_idx (r_pc[5:2]),
      .o_rd_dat (w_rd_dat),
      .o_rd_vld (w_rd_vld)
   );

   assign bus.instr_valid     = w_valid;
   assign bus.instr           = w_rd_dat;
   assign bus.instr_pc        = r_pc;
   assign bus.mem_enable      = w_issue;
   assign bus.mem_addr        = w_issue ? {r_pc[31:6], 6'b0} : 32'd0;
   assign bus.mem_rw          = MEM_READ;
   assign bus.mem_access_size = AS_BURST16;

endmodule

// File: tb/tb_mips_fetch.sv
module tb_mips_fetch;
   import mips_mem_pkg::*;

   localparam logic [31:0] RST_PC = 32'h8002_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mips_fetch_if bus();

   mips_fetch #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] dat;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] req_q[$];
   exp_t        mon_e;
   logic [31:0] mon_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // ---------------- memory model: 16-word burst per request ----------------
   logic        m_busy = 1'b0;
   logic [31:0] m_dout = 32'd0;
   logic [31:0] m_base = 32'd0;
   logic [3:0]  m_idx  = 4'd0;

   assign bus.mem_busy = m_busy;
   assign bus.mem_dout = m_dout;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'h1000_0000 + ((a - RST_PC) >> 2);
   endfunction

   always @(posedge clk) begin
      if (!m_busy) begin
         if (bus.mem_enable) begin
            m_busy <= 1'b1;
            m_base <= bus.mem_addr;
            m_idx  <= 4'd0;
            m_dout <= word_at(bus.mem_addr);
         end
      end else if (m_idx == 4'd15) begin
         m_busy <= 1'b0;
         m_dout <= 32'hDEAD_BEEF;
      end else begin
         m_idx  <= m_idx + 4'd1;
         m_dout <= word_at(m_base + {26'd0, m_idx + 4'd1, 2'b00});
      end
   end

   // ---------------- scoreboard monitor ----------------
   // An instruction presented in a redirect cycle is squashed, not consumed.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL extra_instr: got pc %h instr %h, none expected", bus.instr_pc, bus.instr);
            end else begin
               mon_e = exp_q.pop_front();
               check("instr_pc", bus.instr_pc, mon_e.pc);
               check("instr", bus.instr, mon_e.dat);
            end
         end
         if (bus.mem_enable) begin
            check("req_not_busy", {31'd0, bus.mem_busy}, 32'd0);
            check("req_rw", {31'd0, bus.mem_rw}, {31'd0, MEM_READ});
            check("req_size", {30'd0, bus.mem_access_size}, {30'd0, AS_BURST16});
            if (req_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL extra_req: got addr %h, none expected", bus.mem_addr);
            end else begin
               mon_a = req_q.pop_front();
               check("req_addr", bus.mem_addr, mon_a);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_run(input int first, input int last);
      exp_t e;
      for (int n = first; n <= last; n++) begin
         e.pc  = RST_PC + 32'(n * 4);
         e.dat = 32'h1000_0000 + 32'(n);
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      bus.instr_ready    = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("rst_instr", bus.instr, 32'd0);
      check("rst_instr_pc", bus.instr_pc, RST_PC);
      check("rst_enable", {31'd0, bus.mem_enable}, 32'd0);
      check("rst_addr", bus.mem_addr, 32'd0);
      exp_q.delete();
      req_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_pc(input logic [31:0] pc, input string name);
      int  n = 0;
      logic found = 1'b0;
      while (!found && n < 200) begin
         @(negedge clk);
         n++;
         found = bus.instr_valid && (bus.instr_pc == pc);
      end
      check(name, {31'd0, found}, 32'd1);
   endtask

   task automatic finish_phase(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1 bus.instr_ready = 1'b0;
      check({name, "_drained"}, exp_q.size(), 32'd0);
      repeat (4) @(posedge clk);
      check({name, "_reqs"}, req_q.size(), 32'd0);
   endtask

   task automatic count_to_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.instr_valid && n < 60);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;

      // 1: reset then stream across a line boundary
      do_reset();
      bus.instr_ready = 1'b1;
      req_q.push_back(32'h8002_0000);
      req_q.push_back(32'h8002_0040);
      push_run(0, 19);
      count_to_valid(n);
      check("first_valid_cycle", n, 32'd4);
      finish_phase("stream");

      // 2: backpressure for 5 cycles at pc 0x8002_0008
      do_reset();
      bus.instr_ready = 1'b1;
      req_q.push_back(32'h8002_0000);
      req_q.push_back(32'h8002_0040);
      push_run(0, 19);
      wait_pc(32'h8002_0004, "bp_reach");
      @(posedge clk);
      #1 bus.instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
         check("hold_instr", bus.instr, 32'h1000_0002);
         check("hold_pc", bus.instr_pc, 32'h8002_0008);
         @(posedge clk);
      end
      #1 bus.instr_ready = 1'b1;
      finish_phase("backpressure");

      // 3: same-line redirect during fill (low address bits ignored)
      do_reset();
      bus.instr_ready = 1'b1;
      req_q.push_back(32'h8002_0000);
      req_q.push_back(32'h8002_0040);
      push_run(0, 1);
      push_run(12, 19);
      wait_pc(32'h8002_0004, "near_reach");
      @(posedge clk);
      #1 bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h8002_0031;
      @(posedge clk);
      #1 bus.redirect_valid = 1'b0;
      count_to_valid(n);
      check("near_wait", n, 32'd10);
      check("near_first", bus.instr, 32'h1000_000C);
      finish_phase("near_redirect");

      // 4: cross-line redirect while word 3 is on the bus
      do_reset();
      bus.instr_ready = 1'b1;
      req_q.push_back(32'h8002_0000);
      req_q.push_back(32'h8002_0080);
      push_run(0, 1);
      push_run(33, 35);
      wait_pc(32'h8002_0004, "far_reach");
      @(posedge clk);
      #1 bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h8002_0084;
      @(posedge clk);
      #1 bus.redirect_valid = 1'b0;
      count_to_valid(n);
      check("far_wait", n, 32'd16);
      check("far_first_pc", bus.instr_pc, 32'h8002_0084);
      finish_phase("far_redirect");

      // 5: redirect and ready in the same cycle, target behind current pc
      do_reset();
      bus.instr_ready = 1'b1;
      req_q.push_back(32'h8002_0000);
      push_run(0, 13);
      push_run(5, 7);
      wait_pc(32'h8002_0034, "coll_reach");
      @(posedge clk);
      #1 bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h8002_0014;
      @(posedge clk);
      #1 bus.redirect_valid = 1'b0;
      @(negedge clk);
      check("coll_pc", bus.instr_pc, 32'h8002_0014);
      check("coll_instr", bus.instr, 32'h1000_0005);
      finish_phase("collision");

      // 6: asynchronous reset while word 7 is on the bus
      do_reset();
      bus.instr_ready = 1'b1;
      req_q.push_back(32'h8002_0000);
      push_run(0, 6);
      wait_pc(32'h8002_0018, "mid_reach");
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("mid_rst_instr", bus.instr, 32'd0);
      check("mid_rst_pc", bus.instr_pc, RST_PC);
      check("mid_rst_enable", {31'd0, bus.mem_enable}, 32'd0);
      check("mid_rst_addr", bus.mem_addr, 32'd0);
      check("mid_rst_queue", exp_q.size(), 32'd0);
      req_q.push_back(32'h8002_0000);
      push_run(0, 3);
      @(posedge clk);
      #1 rst_n = 1'b1;
      finish_phase("mid_reset");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
